// File: rtl/adder_arbiter_if.sv
// Purpose: bundles the requester, shared-adder and result-consumer signals
//          of adder_arbiter into one interface.
// Modports:
//   slave  - the arbiter: takes requests, operands, adder results and the
//            consumer ready; drives grants, adder operands, result and busy.
//   master - the surrounding environment (requesters, shared adder and
//            consumer): the mirror image of slave.
// Signals (DATA_WIDTH = operand/sum width):
//   i_req0/i_op0_a/i_op0_b, o_gnt0   requester 0 request, operands, grant
//   i_req1/i_op1_a/i_op1_b, o_gnt1   requester 1 request, operands, grant
//   o_adder_a/o_adder_b              operands to the shared adder
//   i_adder_sum/i_adder_carry        shared adder outputs (carry in bit 0)
//   o_valid/o_id/o_sum/o_carry       held result and its owner
//   i_ready                          consumer accepts the held result
//   o_busy                           result held or any request pending
interface adder_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_req0;
  logic [DATA_WIDTH-1:0] i_op0_a;
  logic [DATA_WIDTH-1:0] i_op0_b;
  logic                  o_gnt0;
  logic                  i_req1;
  logic [DATA_WIDTH-1:0] i_op1_a;
  logic [DATA_WIDTH-1:0] i_op1_b;
  logic                  o_gnt1;
  logic [DATA_WIDTH-1:0] o_adder_a;
  logic [DATA_WIDTH-1:0] o_adder_b;
  logic [DATA_WIDTH-1:0] i_adder_sum;
  logic [DATA_WIDTH-1:0] i_adder_carry;
  logic                  o_valid;
  logic                  o_id;
  logic [DATA_WIDTH-1:0] o_sum;
  logic                  o_carry;
  logic                  i_ready;
  logic                  o_busy;

  modport slave (
    input  i_req0, i_op0_a, i_op0_b,
    input  i_req1, i_op1_a, i_op1_b,
    input  i_adder_sum, i_adder_carry, i_ready,
    output o_gnt0, o_gnt1, o_adder_a, o_adder_b,
    output o_valid, o_id, o_sum, o_carry, o_busy
  );

  modport master (
    output i_req0, i_op0_a, i_op0_b,
    output i_req1, i_op1_a, i_op1_b,
    output i_adder_sum, i_adder_carry, i_ready,
    input  o_gnt0, o_gnt1, o_adder_a, o_adder_b,
    input  o_valid, o_id, o_sum, o_carry, o_busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Purpose: shares one external combinational adder between two requesters
//          (e.g. PC increment on port 0, ALU/address path on port 1).
//          Round-robin arbitration picks a winner, steers its operands to
//          the adder, and captures sum/carry into a one-deep result
//          register with valid/ready back-pressure toward the consumer.
// Ports:
//   clk   - core clock, all state changes on the rising edge
//   rst_n - asynchronous reset, active HIGH despite its name
//   bus   - adder_arbiter_if.slave carrying requests, grants, adder
//           operands/results and the result handshake
module adder_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state;
  logic                  last_gnt;
  logic                  id_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  carry_q;

  logic can_accept;
  logic gnt0;
  logic gnt1;
  logic grant;
  logic sel;

  // Only bit 0 of the adder carry bus is meaningful.
  logic unused_carry_bits;
  assign unused_carry_bits = ^bus.i_adder_carry[DATA_WIDTH-1:1];

  // The result slot can take a new result when empty or being drained this
  // cycle. On a tie the port that did not win last time gets the grant;
  // last_gnt resets to 1 so port 0 wins the first tie. Grants are held off
  // while reset is asserted.
  assign can_accept = (state == EMPTY) || bus.i_ready;
  assign gnt0 = !rst_n && can_accept && bus.i_req0 && (!bus.i_req1 || last_gnt);
  assign gnt1 = !rst_n && can_accept && bus.i_req1 && (!bus.i_req0 || !last_gnt);
  assign grant = gnt0 || gnt1;

  // With no grant the adder keeps seeing the last winner's operands so its
  // inputs do not toggle needlessly.
  assign sel           = grant ? gnt1 : last_gnt;
  assign bus.o_adder_a = sel ? bus.i_op1_a : bus.i_op0_a;
  assign bus.o_adder_b = sel ? bus.i_op1_b : bus.i_op0_b;

  assign bus.o_gnt0  = gnt0;
  assign bus.o_gnt1  = gnt1;
  assign bus.o_valid = (state == FULL);
  assign bus.o_id    = id_q;
  assign bus.o_sum   = sum_q;
  assign bus.o_carry = carry_q;
  assign bus.o_busy  = (state == FULL) || bus.i_req0 || bus.i_req1;

  // A grant always refills the slot (covering same-cycle drain + refill);
  // otherwise a consumed result empties it while the data fields hold.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= EMPTY;
      last_gnt <= 1'b1;
      id_q     <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else if (grant) begin
      state    <= FULL;
      last_gnt <= gnt1;
      id_q     <= gnt1;
      sum_q    <= bus.i_adder_sum;
      carry_q  <= bus.i_adder_carry[0];
    end else if ((state == FULL) && bus.i_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Purpose: directed self-checking bench for adder_arbiter. Models the shared
//          combinational adder, drives hand-built request sequences and
//          compares grants and held results against hand-computed values.
module tb_adder_arbiter;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  adder_arbiter_if #(.DATA_WIDTH(W)) bus ();

  adder_arbiter #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared adder: full-width sum with carry-out delivered in bit 0.
  logic [W:0] full_sum;
  assign full_sum          = {1'b0, bus.o_adder_a} + {1'b0, bus.o_adder_b};
  assign bus.i_adder_sum   = full_sum[W-1:0];
  assign bus.i_adder_carry = {{(W-1){1'b0}}, full_sum[W]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the rising edge, then settle.
  task automatic applyStimulus(input logic r0, input logic [W-1:0] a0,
                               input logic [W-1:0] b0, input logic r1,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic rdy);
    @(posedge clk);
    #1;
    bus.i_req0  = r0;
    bus.i_op0_a = a0;
    bus.i_op0_b = b0;
    bus.i_req1  = r1;
    bus.i_op1_a = a1;
    bus.i_op1_b = b1;
    bus.i_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    bus.i_req0  = 1'b1;
    bus.i_op0_a = '0;
    bus.i_op0_b = '0;
    bus.i_req1  = 1'b0;
    bus.i_op1_a = '0;
    bus.i_op1_b = '0;
    bus.i_ready = 1'b1;

    // Reset state, and no grant while reset is held even with a request up.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("rst_id", 64'(bus.o_id), 64'd0);
    checkOutput("rst_sum", 64'(bus.o_sum), 64'd0);
    checkOutput("rst_carry", 64'(bus.o_carry), 64'd0);
    checkOutput("rst_gnt0", 64'(bus.o_gnt0), 64'd0);
    #2;
    rst_n = 1'b0;

    // Port 0 alone: 5 + 3.
    applyStimulus(1'b1, 32'h5, 32'h3, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("p0_gnt0", 64'(bus.o_gnt0), 64'd1);
    checkOutput("p0_gnt1", 64'(bus.o_gnt1), 64'd0);
    checkOutput("p0_adder_a", 64'(bus.o_adder_a), 64'h5);
    checkOutput("p0_adder_b", 64'(bus.o_adder_b), 64'h3);

    // Port 1 alone: 0xFFFFFFFF + 2 wraps with carry; port 0 result visible.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b1);
    checkOutput("p0_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("p0_id", 64'(bus.o_id), 64'd0);
    checkOutput("p0_sum", 64'(bus.o_sum), 64'h8);
    checkOutput("p0_carry", 64'(bus.o_carry), 64'd0);
    checkOutput("p1_gnt1", 64'(bus.o_gnt1), 64'd1);
    checkOutput("p1_gnt0", 64'(bus.o_gnt0), 64'd0);

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("p1_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("p1_id", 64'(bus.o_id), 64'd1);
    checkOutput("p1_sum", 64'(bus.o_sum), 64'h1);
    checkOutput("p1_carry", 64'(bus.o_carry), 64'd1);
    checkOutput("p1_busy", 64'(bus.o_busy), 64'd1);

    // Drained with nothing pending: empty and idle.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("drain_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("drain_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("drain_sum_hold", 64'(bus.o_sum), 64'h1);

    // Continuous dual requests: grants alternate starting with port 0;
    // port 0 adds 0x10, port 1 adds 0x100 to the cycle index.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 32'(k), 32'h10, 1'b1, 32'(k), 32'h100, 1'b1);
      checkOutput("rr_gnt0", 64'(bus.o_gnt0), 64'((k % 2) == 0));
      checkOutput("rr_gnt1", 64'(bus.o_gnt1), 64'((k % 2) == 1));
      if (k == 0) begin
        checkOutput("rr_valid0", 64'(bus.o_valid), 64'd0);
      end else begin
        checkOutput("rr_id", 64'(bus.o_id), 64'((k - 1) % 2));
        checkOutput("rr_sum", 64'(bus.o_sum),
                    64'((k - 1) + (((k - 1) % 2) == 0 ? 32'h10 : 32'h100)));
      end
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("rr_last_id", 64'(bus.o_id), 64'd1);
    checkOutput("rr_last_sum", 64'(bus.o_sum), 64'h105);

    // Drain and refill in the same cycle: port 0 computes 0x20 + 0x22.
    applyStimulus(1'b1, 32'h20, 32'h22, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("refill_gnt0", 64'(bus.o_gnt0), 64'd1);

    // Stall three cycles with both requesting: result frozen, no grants.
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 32'h30, 32'h1, 1'b1, 32'h40, 32'h3, 1'b0);
      checkOutput("stall_valid", 64'(bus.o_valid), 64'd1);
      checkOutput("stall_sum", 64'(bus.o_sum), 64'h42);
      checkOutput("stall_id", 64'(bus.o_id), 64'd0);
      checkOutput("stall_gnt0", 64'(bus.o_gnt0), 64'd0);
      checkOutput("stall_gnt1", 64'(bus.o_gnt1), 64'd0);
    end

    // Ready returns: port 1 (not last winner) granted in the same cycle.
    applyStimulus(1'b1, 32'h30, 32'h1, 1'b1, 32'h40, 32'h3, 1'b1);
    checkOutput("unstall_gnt1", 64'(bus.o_gnt1), 64'd1);
    checkOutput("unstall_gnt0", 64'(bus.o_gnt0), 64'd0);
    checkOutput("unstall_sum_old", 64'(bus.o_sum), 64'h42);

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("unstall_id", 64'(bus.o_id), 64'd1);
    checkOutput("unstall_sum", 64'(bus.o_sum), 64'h43);
    checkOutput("unstall_valid", 64'(bus.o_valid), 64'd1);

    // Asynchronous reset mid-cycle while a result is held.
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("async_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("async_sum", 64'(bus.o_sum), 64'd0);
    #2;
    rst_n = 1'b0;

    // After reset, tie goes to port 0; port 1 then withdraws before winning
    // while port 0 keeps a grant stream going.
    applyStimulus(1'b1, 32'h100, 32'h1, 1'b1, 32'h200, 32'h2, 1'b1);
    checkOutput("post_rst_gnt0", 64'(bus.o_gnt0), 64'd1);
    checkOutput("post_rst_gnt1", 64'(bus.o_gnt1), 64'd0);

    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, 32'(32'h110 + j), 32'h1, 1'b0, 32'h200, 32'h2, 1'b1);
      checkOutput("wd_gnt0", 64'(bus.o_gnt0), 64'd1);
      checkOutput("wd_gnt1", 64'(bus.o_gnt1), 64'd0);
      checkOutput("wd_id", 64'(bus.o_id), 64'd0);
      checkOutput("wd_sum", 64'(bus.o_sum),
                  (j == 0) ? 64'h101 : 64'(32'h110 + (j - 1) + 1));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("wd_last_id", 64'(bus.o_id), 64'd0);
    checkOutput("wd_last_sum", 64'(bus.o_sum), 64'h113);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
